test_status_monitor: RTL

- Synthesizable end-of-test detector that sits directly downstream of the CPU_TOP register-file writeback port.
- Keeps shadow copies of the signature register (x17) and the test-ID register (x10) from writeback traffic.
- Declares PASS/FAIL once a magic signature has held in x17 for a programmed number of cycles; declares TIMEOUT if neither resolves in time.
- Replaces the bench-side polling of register values so the same check works on FPGA (LED/UART hookup) and in simulation.

---
 rtl/test_status_monitor.sv | 107 ++++++++++
 1 files changed

// File: rtl/test_status_monitor.sv
// End-of-test detector on the register-file writeback port: confirms a magic
// signature held in the signature register, or flags a timeout.
module test_status_monitor #(
  parameter logic [31:0] PASS_SIG       = 32'h0D000721,
  parameter logic [31:0] FAIL_SIG       = 32'h01919810,
  parameter int          SIG_REG        = 17,
  parameter int          ID_REG         = 10,
  parameter int          STABLE_CYCLES  = 3,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      fail_id,
  output logic [CNT_W-1:0] cycles
);

  localparam int STB_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES);
  localparam logic [CNT_W:0]   TO_LIM  = (CNT_W+1)'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {RUN, ARMED, DONE_PASS, DONE_FAIL, DONE_TIMEOUT} state_t;

  state_t           state, state_n;
  logic [31:0]      sig_shadow;
  logic [31:0]      id_shadow;
  logic [31:0]      id_next;
  logic [STB_W-1:0] stable_cnt, stable_n;
  logic             active;
  logic             sig_wr, id_wr, wr_magic;
  logic             timeout_hit;
  logic [CNT_W-1:0] cycles_inc;

  assign active      = (state == RUN) || (state == ARMED);
  assign sig_wr      = wb_en && (wb_rd != 5'd0) && (wb_rd == 5'(SIG_REG));
  assign id_wr       = wb_en && (wb_rd != 5'd0) && (wb_rd == 5'(ID_REG));
  assign wr_magic    = sig_wr && ((wb_data == PASS_SIG) || (wb_data == FAIL_SIG));
  assign id_next     = id_wr ? wb_data : id_shadow;
  assign cycles_inc  = (cycles == {CNT_W{1'b1}}) ? cycles : cycles + 1'b1;
  assign timeout_hit = (({1'b0, cycles} + 1'b1) == TO_LIM);

  // While ARMED, sig_shadow always holds the armed magic value, because any
  // non-magic signature write drops the FSM back to RUN.
  always_comb begin
    state_n  = state;
    stable_n = stable_cnt;
    case (state)
      RUN: begin
        if (wr_magic) begin
          state_n  = ARMED;
          stable_n = STB_W'(1);
        end
      end
      ARMED: begin
        if (sig_wr && (wb_data != sig_shadow)) begin
          if (wr_magic) begin
            stable_n = STB_W'(1);
          end else begin
            state_n  = RUN;
            stable_n = '0;
          end
        end else if (stable_cnt == STB_MAX) begin
          state_n = (sig_shadow == FAIL_SIG) ? DONE_FAIL : DONE_PASS;
        end else begin
          stable_n = stable_cnt + STB_W'(1);
        end
      end
      default: ;
    endcase
    if (active && timeout_hit && (state_n != DONE_PASS) && (state_n != DONE_FAIL)) begin
      state_n = DONE_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      sig_shadow <= '0;
      id_shadow  <= '0;
      stable_cnt <= '0;
      cycles     <= '0;
      fail_id    <= '0;
    end else begin
      state      <= state_n;
      stable_cnt <= stable_n;
      if (active) begin
        cycles <= cycles_inc;
        if (sig_wr) sig_shadow <= wb_data;
        if (id_wr)  id_shadow  <= wb_data;
        if (state_n == DONE_FAIL) fail_id <= id_next;
      end
    end
  end

  assign pass    = (state == DONE_PASS);
  assign fail    = (state == DONE_FAIL);
  assign timeout = (state == DONE_TIMEOUT);
  assign done    = pass || fail || timeout;

endmodule
